// File: rtl/input_debounce_pkg.sv
// Shared debounce definitions: FSM state codes, CSR register offsets, counter width and helpers.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package input_debounce_pkg;

  // Tick counter width; DEB_TIME is programmed in the same unit.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit 1 of the state is the debounced level, so out is a plain wire from the state register.
  // Bit 0 marks "pending": the synchronised input disagrees with the level and is being timed.
  localparam logic [1:0] ST_LO     = 2'b00;
  localparam logic [1:0] ST_PEND_H = 2'b01;
  localparam logic [1:0] ST_HI     = 2'b10;
  localparam logic [1:0] ST_PEND_L = 2'b11;

  // CSR offsets from BASE_ADDR.
  localparam logic [4:0] REG_TIME   = 5'd0;
  localparam logic [4:0] REG_BYPASS = 5'd1;
  localparam logic [4:0] REG_GLITCH = 5'd2;

  // Saturating increment: the tick counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, LO/PEND_H/HI/PEND_L filter FSM and tick counter.
// Latency: 3 clk pad-to-out when unfiltered; DEB_TIME ce ticks (+0/-1 tick) plus 3 clk when filtered.
// Backpressure: none; the pad is sampled every clk and strobes are single-cycle with no handshake.
module input_debounce_channel
  import input_debounce_pkg::*;
#(
  parameter bit GLITCH_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [CNT_W-1:0] deb_time,
  input  logic             bypass,
  input  logic             dfl,
  input  logic             in,
  output logic             out,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             glitch
);

  logic             sync1;
  logic             sync2;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             filt_off;
  logic             reached;

  // A zero debounce time behaves exactly like bypass: the level tracks the synchroniser.
  assign filt_off = bypass || (deb_time == '0);
  assign cnt_inc  = sat_inc(cnt);
  // Compare the count this tick would reach, so DEB_TIME=N switches on the Nth tick.
  // A new DEB_TIME is used here directly, so a shorter value can end a pending period early.
  assign reached  = (cnt_inc >= deb_time);
  assign out      = state[1];

  // First synchroniser stage: deliberately unreset so it is a bare metastability flop.
  always_ff @(posedge clk) begin
    sync1 <= in;
  end

  // Next-state logic for the filter FSM and its tick counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (filt_off) begin
      state_nxt = sync2 ? ST_HI : ST_LO;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_LO: begin
          if (sync2) begin
            state_nxt = ST_PEND_H;
            cnt_nxt   = '0;
          end
        end
        ST_PEND_H: begin
          if (!sync2) begin
            state_nxt = ST_LO;
            cnt_nxt   = '0;
          end else if (ce) begin
            if (reached) begin
              state_nxt = ST_HI;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        ST_HI: begin
          if (!sync2) begin
            state_nxt = ST_PEND_L;
            cnt_nxt   = '0;
          end
        end
        ST_PEND_L: begin
          if (sync2) begin
            state_nxt = ST_HI;
            cnt_nxt   = '0;
          end else if (ce) begin
            if (reached) begin
              state_nxt = ST_LO;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        default: begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stage 2, state and strobes; stage 2 resets to the default level so release causes no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync2    <= dfl;
      state    <= dfl ? ST_HI : ST_LO;
      cnt      <= '0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      sync2    <= sync1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pos_edge <= state_nxt[1] & ~state[1];
      neg_edge <= ~state_nxt[1] & state[1];
    end
  end

  if (GLITCH_EN) begin : g_glitch
    logic glitch_q;
    logic ret_stable;

    // A pending channel that falls back to its current level was a rejected glitch.
    assign ret_stable = !filt_off &&
                        (((state == ST_PEND_H) && !sync2) || ((state == ST_PEND_L) && sync2));

    // Registered one-cycle glitch event, aligned with the state returning to stable.
    always_ff @(posedge clk) begin
      if (rst) begin
        glitch_q <= 1'b0;
      end else begin
        glitch_q <= ret_stable;
      end
    end

    assign glitch = glitch_q;
  end else begin : g_no_glitch
    assign glitch = 1'b0;
  end

endmodule

// File: rtl/input_debounce.sv
// Debouncer for slow board inputs: CSR decode, optional sticky glitch register, one channel per input.
// Latency: 3 clk pad-to-out unfiltered, DEB_TIME ce ticks (+0/-1) plus 3 clk filtered; CSR reads combinational.
// Backpressure: none; CSR writes land the cycle after csr_we. `INPUT_DEBOUNCE_GLITCH_EN adds GLITCH at +2.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR  = 5'h00,
  parameter int         NUM_INPUTS = 5,
  parameter logic [7:0] DFL_STATE  = 8'h00,
  parameter logic [7:0] DFL_TIME   = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [4:0]            csr_a,
  input  logic [7:0]            csr_di,
  input  logic                  csr_we,
  output logic [7:0]            csr_do,
  input  logic [NUM_INPUTS-1:0] in,
  output logic [NUM_INPUTS-1:0] out,
  output logic [NUM_INPUTS-1:0] out_posedge,
  output logic [NUM_INPUTS-1:0] out_negedge
);

  localparam logic [4:0] ADDR_TIME   = BASE_ADDR + REG_TIME;
  localparam logic [4:0] ADDR_BYPASS = BASE_ADDR + REG_BYPASS;

  logic [CNT_W-1:0]      deb_time_q;
  logic [NUM_INPUTS-1:0] bypass_q;

`ifdef INPUT_DEBOUNCE_GLITCH_EN
  localparam bit         GLITCH_EN   = 1'b1;
  localparam logic [4:0] ADDR_GLITCH = BASE_ADDR + REG_GLITCH;

  logic [NUM_INPUTS-1:0] glitch_pulse;
  logic [NUM_INPUTS-1:0] glitch_q;
  logic [NUM_INPUTS-1:0] glitch_clr;

  assign glitch_clr = (csr_we && (csr_a == ADDR_GLITCH)) ? csr_di[NUM_INPUTS-1:0] : '0;

  // Sticky rw1c glitch flags; a new event wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= (glitch_q & ~glitch_clr) | glitch_pulse;
    end
  end
`else
  localparam bit GLITCH_EN = 1'b0;

  // Channels tie their glitch output low in this build; nothing consumes it.
  logic [NUM_INPUTS-1:0] glitch_unused;
`endif

  // Writable control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_time_q <= DFL_TIME;
      bypass_q   <= '0;
    end else if (csr_we) begin
      if (csr_a == ADDR_TIME) begin
        deb_time_q <= csr_di;
      end
      if (csr_a == ADDR_BYPASS) begin
        bypass_q <= csr_di[NUM_INPUTS-1:0];
      end
    end
  end

  // Read mux onto the shared OR-bus: zero whenever the address is not one of ours.
  always_comb begin
    csr_do = '0;
    if (csr_a == ADDR_TIME) begin
      csr_do = deb_time_q;
    end else if (csr_a == ADDR_BYPASS) begin
      csr_do[NUM_INPUTS-1:0] = bypass_q;
`ifdef INPUT_DEBOUNCE_GLITCH_EN
    end else if (csr_a == ADDR_GLITCH) begin
      csr_do[NUM_INPUTS-1:0] = glitch_q;
`endif
    end
  end

  for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_ch
    input_debounce_channel #(
      .GLITCH_EN(GLITCH_EN)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .deb_time (deb_time_q),
      .bypass   (bypass_q[n]),
      .dfl      (DFL_STATE[n]),
      .in       (in[n]),
      .out      (out[n]),
      .pos_edge (out_posedge[n]),
      .neg_edge (out_negedge[n]),
`ifdef INPUT_DEBOUNCE_GLITCH_EN
      .glitch   (glitch_pulse[n])
`else
      .glitch   (glitch_unused[n])
`endif
    );
  end

endmodule
